// File: rtl/mcpu_program_loader_if.sv
// Byte-stream input and RAM write bus between the program loader and its neighbours.
// The slave side is the loader; the master side feeds bytes and observes RAM writes.
interface mcpu_program_loader_if #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_SIZE = 8
);
  logic [7:0]           in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic                 mem_we;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mcpu_program_loader.sv
// Boot loader: assembles a byte stream into 16-bit words and writes them to MCPU RAM
// from address 0, holding the CPU in reset until the final word is written.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_COUNT | waiting for the word-count byte (0 means a full RAM)
// S_HI    | waiting for the high byte of the next word
// S_LO    | waiting for the low byte of the next word
// S_WRITE | single-cycle RAM write, then advance address / count
// S_DONE  | program running, CPU out of reset; start re-arms
module mcpu_program_loader #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_SIZE = 8,
  parameter int RAM_SIZE  = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  mcpu_program_loader_if.slave  bus,
  output logic                  cpu_reset,
  output logic                  done
);

  localparam int CNT_W = ADDR_SIZE + 1;

  typedef enum logic [2:0] {
    S_COUNT,
    S_HI,
    S_LO,
    S_WRITE,
    S_DONE
  } state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     remaining, remaining_nxt;
  logic [ADDR_SIZE-1:0] addr_q, addr_nxt;
  logic [WORD_SIZE-1:0] wdata_q, wdata_nxt;
  logic                 ready_q, ready_nxt;
  logic                 we_q, we_nxt;
  logic                 cpu_reset_q, cpu_reset_nxt;
  logic                 done_q, done_nxt;
  logic                 accept;

  assign accept        = bus.in_valid & ready_q;
  assign bus.in_ready  = ready_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign cpu_reset     = cpu_reset_q;
  assign done          = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_COUNT;
      remaining   <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ready_q     <= 1'b0;
      we_q        <= 1'b0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      remaining   <= remaining_nxt;
      addr_q      <= addr_nxt;
      wdata_q     <= wdata_nxt;
      ready_q     <= ready_nxt;
      we_q        <= we_nxt;
      cpu_reset_q <= cpu_reset_nxt;
      done_q      <= done_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    addr_nxt      = addr_q;
    wdata_nxt     = wdata_q;
    we_nxt        = 1'b0;
    case (state)
      S_COUNT: begin
        if (accept) begin
          remaining_nxt = (bus.in_data == 8'd0) ? CNT_W'(RAM_SIZE) : CNT_W'(bus.in_data);
          addr_nxt      = '0;
          state_nxt     = S_HI;
        end
      end
      S_HI: begin
        if (accept) begin
          wdata_nxt[WORD_SIZE-1 -: 8] = bus.in_data;
          state_nxt                   = S_LO;
        end
      end
      S_LO: begin
        if (accept) begin
          wdata_nxt[7:0] = bus.in_data;
          we_nxt         = 1'b1;
          state_nxt      = S_WRITE;
        end
      end
      S_WRITE: begin
        remaining_nxt = remaining - 1'b1;
        addr_nxt      = addr_q + 1'b1;
        state_nxt     = (remaining == CNT_W'(1)) ? S_DONE : S_HI;
      end
      S_DONE: begin
        if (start) begin
          addr_nxt  = '0;
          state_nxt = S_COUNT;
        end
      end
      default: state_nxt = S_COUNT;
    endcase
    // Outputs are registered, so they follow the state being entered.
    ready_nxt     = (state_nxt == S_COUNT) || (state_nxt == S_HI) || (state_nxt == S_LO);
    cpu_reset_nxt = (state_nxt != S_DONE);
    done_nxt      = (state_nxt == S_DONE);
  end

endmodule

// File: tb/tb_mcpu_program_loader.sv
// Scoreboard bench for the program loader: stimulus queues expected RAM writes,
// a negedge monitor pops and compares every mem_we pulse.
module tb_mcpu_program_loader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic cpu_reset, done;
  int   total = 0;
  int   bad = 0;
  logic [23:0] exp_q[$];

  mcpu_program_loader_if lif();

  mcpu_program_loader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (lif),
    .cpu_reset (cpu_reset),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every RAM write must match the oldest expected write.
  always @(negedge clk) begin
    if (lif.mem_we) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr=%0h data=%0h expected none", lif.mem_addr, lif.mem_wdata);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        if ({lif.mem_addr, lif.mem_wdata} !== e) begin
          bad++;
          $display("FAIL write: got addr=%0h data=%0h expected addr=%0h data=%0h",
                   lif.mem_addr, lif.mem_wdata, e[23:16], e[15:0]);
        end
      end
    end
  end

  // Offers one byte and returns one step after the edge that accepted it.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit acc = 1'b0;
    int n = 0;
    if (gap) begin
      lif.in_valid = 1'b0;
      @(posedge clk); #1;
    end
    lif.in_data  = b;
    lif.in_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = lif.in_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got no accept expected accept of %0h", b);
    end
  endtask

  task automatic send_word(input logic [7:0] addr, input logic [7:0] hi, input logic [7:0] lo, input bit gap);
    exp_q.push_back({addr, hi, lo});
    send_byte(hi, gap);
    send_byte(lo, gap);
    lif.in_valid = 1'b0;
  endtask

  // Called right after the final low byte: WRITE cycle, then DONE.
  task automatic check_release(input string tag);
    @(negedge clk);
    chk({tag, "_we_last"}, int'(lif.mem_we), 1);
    chk({tag, "_cpurst_in_write"}, int'(cpu_reset), 1);
    @(negedge clk);
    chk({tag, "_cpurst_released"}, int'(cpu_reset), 0);
    chk({tag, "_done"}, int'(done), 1);
    chk({tag, "_ready_done"}, int'(lif.in_ready), 0);
  endtask

  initial begin
    lif.in_data  = 8'h00;
    lif.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", int'(lif.in_ready), 0);
    chk("rst_we", int'(lif.mem_we), 0);
    chk("rst_addr", int'(lif.mem_addr), 0);
    chk("rst_wdata", int'(lif.mem_wdata), 0);
    chk("rst_cpurst", int'(cpu_reset), 1);
    chk("rst_done", int'(done), 0);
    @(negedge clk);
    chk("ready_after_rst", int'(lif.in_ready), 1);
    @(posedge clk); #1;

    // Back-to-back stream, valid held high.
    send_byte(8'h03, 1'b0);
    send_word(8'd0, 8'h10, 8'hAB, 1'b0);
    send_word(8'd1, 8'h20, 8'hCD, 1'b0);
    send_word(8'd2, 8'h3F, 8'h01, 1'b0);
    check_release("burst");

    // Same stream with an idle cycle before every byte.
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    send_byte(8'h03, 1'b1);
    send_word(8'd0, 8'h10, 8'hAB, 1'b1);
    send_word(8'd1, 8'h20, 8'hCD, 1'b1);
    send_word(8'd2, 8'h3F, 8'h01, 1'b1);
    check_release("gappy");

    // Full 256-word load with count byte 0.
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] a;
      a = 8'(i);
      send_word(a, a ^ 8'h5A, ~a, 1'b0);
    end
    check_release("full");
    lif.in_data  = 8'h77;
    lif.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("extra_byte_not_ready", int'(lif.in_ready), 0);
      chk("extra_byte_cpurst", int'(cpu_reset), 0);
    end
    lif.in_valid = 1'b0;

    // Reset after the high byte of word 1.
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    send_byte(8'h03, 1'b0);
    send_word(8'd0, 8'h10, 8'hAB, 1'b0);
    send_byte(8'h20, 1'b0);
    lif.in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_cpurst", int'(cpu_reset), 1);
    chk("midrst_ready", int'(lif.in_ready), 0);
    chk("midrst_addr", int'(lif.mem_addr), 0);
    chk("midrst_wdata", int'(lif.mem_wdata), 0);
    chk("midrst_done", int'(done), 0);
    @(posedge clk); #1;
    send_byte(8'h01, 1'b0);
    send_word(8'd0, 8'h55, 8'hAA, 1'b0);
    check_release("midrst");
    @(negedge clk);
    chk("done_addr_advanced", int'(lif.mem_addr), 1);

    // Re-arm from DONE with start.
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("start_cpurst", int'(cpu_reset), 1);
    chk("start_done", int'(done), 0);
    chk("start_addr", int'(lif.mem_addr), 0);
    chk("start_ready", int'(lif.in_ready), 1);
    @(posedge clk); #1;
    send_byte(8'h01, 1'b0);
    send_word(8'd0, 8'h00, 8'h00, 1'b0);
    check_release("restart");

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
